// File: rtl/cpu_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package cpu_timer_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD_L = 3'd2;
  localparam logic [2:0] OFF_PERIOD_H = 3'd3;
  localparam logic [2:0] OFF_SNAP_L   = 3'd4;
  localparam logic [2:0] OFF_SNAP_H   = 3'd5;
  localparam logic [2:0] OFF_CMP_L    = 3'd6;
  localparam logic [2:0] OFF_CMP_H    = 3'd7;

  localparam int CTRL_ITO    = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;
  localparam int CTRL_PWM_EN = 4;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  function automatic logic [7:0] offset_onehot(input logic [2:0] off);
    return 8'(1) << off;
  endfunction

endpackage

// File: rtl/cpu_multi_timer_if.sv
// Avalon-MM slave bus bundle for the timer: {channel, offset} address, 16-bit data.
interface cpu_multi_timer_if #(
  parameter int NUM_CH = 4
);
  localparam int ADDR_W = $clog2(NUM_CH) + 3;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/cpu_timer_channel.sv
// One timer channel: down-counter with period/compare/snapshot registers,
// timeout and run flags, and a registered compare-driven PWM output.
module cpu_timer_channel
  import cpu_timer_pkg::*;
#(
  parameter int          CNT_W          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h1869F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      wr_i,
  input  logic [15:0]     wdata_i,
  output logic [7:0][15:0] rd_o,
  output logic            irq_o,
  output logic            pwm_o
);

  localparam logic [CNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ito_q, ito_d;
  logic             cont_q, cont_d;
  logic             pwm_en_q, pwm_en_d;
  logic             to_q, to_d;
  logic             run_q, run_d;
  logic             force_q, force_d;
  logic             zero_q, zero_d;
  logic             pwm_q, pwm_d;

  logic             start, stop, zero;
  logic [15:0]      status_w, control_w;

  function automatic logic [15:0] hi_half(input logic [CNT_W-1:0] v);
    return 16'(v >> 16);
  endfunction

  assign zero  = (cnt_q == '0);
  assign start = wr_i[OFF_CONTROL] & wdata_i[CTRL_START];
  assign stop  = wr_i[OFF_CONTROL] & wdata_i[CTRL_STOP];

  always_comb begin
    period_d = period_q;
    cmp_d    = cmp_q;
    if (wr_i[OFF_PERIOD_L]) period_d[15:0]      = wdata_i;
    if (wr_i[OFF_PERIOD_H]) period_d[CNT_W-1:16] = wdata_i[CNT_W-17:0];
    if (wr_i[OFF_CMP_L])    cmp_d[15:0]         = wdata_i;
    if (wr_i[OFF_CMP_H])    cmp_d[CNT_W-1:16]   = wdata_i[CNT_W-17:0];

    snap_d  = (wr_i[OFF_SNAP_L] | wr_i[OFF_SNAP_H]) ? cnt_q : snap_q;
    force_d = wr_i[OFF_PERIOD_L] | wr_i[OFF_PERIOD_H];

    ito_d    = ito_q;
    cont_d   = cont_q;
    pwm_en_d = pwm_en_q;
    if (wr_i[OFF_CONTROL]) begin
      ito_d    = wdata_i[CTRL_ITO];
      cont_d   = wdata_i[CTRL_CONT];
      pwm_en_d = wdata_i[CTRL_PWM_EN];
    end

    // force_reload lands one cycle after the period write, so it loads the new value
    cnt_d = cnt_q;
    if (run_q | force_q)
      cnt_d = (zero | force_q) ? period_q : cnt_q - CNT_W'(1);

    run_d = run_q;
    if (start)
      run_d = 1'b1;
    else if (stop | force_q | (zero & ~cont_q))
      run_d = 1'b0;

    zero_d = zero;
    to_d   = to_q;
    if (wr_i[OFF_STATUS])
      to_d = 1'b0;
    else if (zero & ~zero_q)
      to_d = 1'b1;

    pwm_d = pwm_en_q & run_q & (cnt_q < cmp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= RST_PERIOD;
      cmp_q    <= '0;
      snap_q   <= '0;
      cnt_q    <= RST_PERIOD;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      pwm_en_q <= 1'b0;
      to_q     <= 1'b0;
      run_q    <= 1'b0;
      force_q  <= 1'b0;
      zero_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      cmp_q    <= cmp_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      pwm_en_q <= pwm_en_d;
      to_q     <= to_d;
      run_q    <= run_d;
      force_q  <= force_d;
      zero_q   <= zero_d;
      pwm_q    <= pwm_d;
    end
  end

  always_comb begin
    status_w                = '0;
    status_w[STAT_TO]       = to_q;
    status_w[STAT_RUN]      = run_q;
    control_w               = '0;
    control_w[CTRL_ITO]     = ito_q;
    control_w[CTRL_CONT]    = cont_q;
    control_w[CTRL_PWM_EN]  = pwm_en_q;
  end

  assign rd_o[OFF_STATUS]   = status_w;
  assign rd_o[OFF_CONTROL]  = control_w;
  assign rd_o[OFF_PERIOD_L] = period_q[15:0];
  assign rd_o[OFF_PERIOD_H] = hi_half(period_q);
  assign rd_o[OFF_SNAP_L]   = snap_q[15:0];
  assign rd_o[OFF_SNAP_H]   = hi_half(snap_q);
  assign rd_o[OFF_CMP_L]    = cmp_q[15:0];
  assign rd_o[OFF_CMP_H]    = hi_half(cmp_q);

  assign irq_o = to_q & ito_q;
  assign pwm_o = pwm_q;

endmodule

// File: rtl/cpu_multi_timer.sv
// Multi-channel interval timer: address decode, channel array, registered
// read mux and a single ORed interrupt line.
module cpu_multi_timer
  import cpu_timer_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h1869F
) (
  input  logic              clk,
  input  logic              reset,
  cpu_multi_timer_if.slave  bus,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int ADDR_W = $clog2(NUM_CH) + 3;

  logic [ADDR_W-1:0]  ch_idx;
  logic [2:0]         off;
  logic               wr_stb;
  logic [7:0]         wr_ch [NUM_CH];
  logic [7:0][15:0]   rd_ch [NUM_CH];
  logic [NUM_CH-1:0]  irq_ch;
  logic [15:0]        rdata_q, rdata_d;

  assign ch_idx = bus.address >> 3;
  assign off    = bus.address[2:0];
  assign wr_stb = bus.chipselect & ~bus.write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_ch[g] = (wr_stb && ch_idx == ADDR_W'(g)) ? offset_onehot(off) : 8'd0;

    cpu_timer_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (reset),
      .wr_i    (wr_ch[g]),
      .wdata_i (bus.writedata),
      .rd_o    (rd_ch[g]),
      .irq_o   (irq_ch[g]),
      .pwm_o   (pwm_out[g])
    );
  end

  // Addresses past the last channel match no instance and read back as zero
  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_idx == ADDR_W'(c)) rdata_d = rd_ch[c][off];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign bus.readdata = rdata_q;
  assign irq          = |irq_ch;

endmodule

// File: tb/tb_cpu_multi_timer.sv
// Directed bench for cpu_multi_timer with a read scoreboard and immediate assertions.
module tb_cpu_multi_timer;

  localparam int NCH = 5;
  localparam int AW  = $clog2(NCH) + 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           irq;
  logic [NCH-1:0] pwm_out;

  cpu_multi_timer_if #(.NUM_CH(NCH)) bus ();

  cpu_multi_timer #(
    .NUM_CH         (NCH),
    .CNT_W          (32),
    .DEFAULT_PERIOD (32'h1869F)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    string       tag;
  } sb_t;

  sb_t sbq[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int off, input logic [15:0] d);
    bus.address    = AW'((ch << 3) | off);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    cyc();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int off, input logic [15:0] exp);
    sb_t e;
    bus.address    = AW'((ch << 3) | off);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    e.exp = exp;
    e.tag = $sformatf("rd_ch%0d_off%0d", ch, off);
    sbq.push_back(e);
    cyc();
    bus.chipselect = 1'b0;
    e = sbq.pop_front();
    check(e.tag, 32'(bus.readdata), 32'(e.exp));
  endtask

  initial begin
    int cnt;
    logic e_pwm;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // reset state
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_readdata", 32'(bus.readdata), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    rd(0, 2, 16'h869F);
    rd(0, 3, 16'h0001);
    rd(0, 0, 16'h0000);

    // ch1 continuous, period 5, ITO
    wr(1, 2, 16'd5);
    wr(1, 3, 16'd0);
    cyc();
    wr(1, 1, 16'h0007);
    repeat (5) cyc();
    check("ch1_irq_at_zero", 32'(irq), 32'h0);
    cyc();
    check("ch1_irq_rise", 32'(irq), 32'h1);
    rd(1, 0, 16'h0003);
    wr(1, 0, 16'h0000);
    check("ch1_irq_clear", 32'(irq), 32'h0);
    repeat (3) cyc();
    check("ch1_irq_before_2nd", 32'(irq), 32'h0);
    cyc();
    check("ch1_irq_2nd", 32'(irq), 32'h1);
    wr(1, 1, 16'h0008);
    wr(1, 0, 16'h0000);
    check("ch1_stopped_irq", 32'(irq), 32'h0);

    // ch2 one-shot, period 3
    wr(2, 2, 16'd3);
    wr(2, 3, 16'd0);
    cyc();
    wr(2, 1, 16'h0005);
    repeat (3) cyc();
    check("ch2_irq_pre", 32'(irq), 32'h0);
    rd(2, 0, 16'h0002);
    check("ch2_irq", 32'(irq), 32'h1);
    rd(2, 0, 16'h0001);
    wr(2, 4, 16'h0000);
    rd(2, 4, 16'h0003);
    wr(2, 0, 16'h0000);
    repeat (10) cyc();
    check("ch2_single_to_irq", 32'(irq), 32'h0);
    rd(2, 0, 16'h0000);

    // ch2 status write coinciding with the zero edge
    wr(2, 1, 16'h0005);
    repeat (3) cyc();
    wr(2, 0, 16'h0000);
    check("ch2_edge_status_irq", 32'(irq), 32'h0);
    rd(2, 0, 16'h0000);

    // ch0 PWM: period 9, compare 4
    wr(0, 2, 16'd9);
    wr(0, 3, 16'd0);
    wr(0, 6, 16'd4);
    wr(0, 7, 16'd0);
    wr(0, 1, 16'h0016);
    cnt = 9;
    for (int i = 0; i < 20; i++) begin
      e_pwm = (cnt < 4);
      cnt = (cnt == 0) ? 9 : cnt - 1;
      cyc();
      check($sformatf("ch0_pwm_%0d", i), 32'(pwm_out[0]), 32'(e_pwm));
    end
    wr(0, 1, 16'h0018);
    cyc();
    check("ch0_pwm_stop", 32'(pwm_out[0]), 32'h0);
    rd(0, 1, 16'h0010);

    // ch3 snapshot and mid-count period write
    wr(3, 1, 16'h0006);
    repeat (3) cyc();
    wr(3, 4, 16'h0000);
    rd(3, 4, 16'h869C);
    rd(3, 5, 16'h0001);
    wr(3, 2, 16'h0010);
    cyc();
    wr(3, 4, 16'h0000);
    rd(3, 4, 16'h0010);
    rd(3, 5, 16'h0001);
    rd(3, 0, 16'h0000);

    // ch4 START and STOP together
    wr(4, 1, 16'h000C);
    rd(4, 0, 16'h0002);
    wr(4, 1, 16'h0008);

    // channel index past the last channel
    wr(NCH, 2, 16'h1234);
    wr(NCH, 1, 16'h0007);
    rd(NCH, 2, 16'h0000);
    rd(NCH, 1, 16'h0000);
    rd(4, 2, 16'h869F);
    rd(4, 1, 16'h0000);
    check("oor_irq", 32'(irq), 32'h0);

    // reset while ch1 is counting with a pending interrupt
    wr(1, 1, 16'h0007);
    repeat (10) cyc();
    check("pre_reset_irq", 32'(irq), 32'h1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_reset_irq", 32'(irq), 32'h0);
    check("mid_reset_pwm", 32'(pwm_out), 32'h0);
    rd(1, 0, 16'h0000);
    rd(1, 1, 16'h0000);
    rd(2, 2, 16'h869F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
